mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 1, width of each requester's data and of out_data.
REQ-002 Parameter PRIO_RESET, default 0, requester favoured after reset (0 = A, 1 = B).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  requester A has data.
REQ-006 a_data  input  DATA_W  requester A data.
REQ-007 a_ready  output  1  requester A data accepted this cycle.
REQ-008 b_valid, b_data, b_ready  as REQ-005..007 for requester B.
REQ-009 out_valid  output  1  output register holds data.
REQ-010 out_data  output  DATA_W  muxed data.
REQ-011 out_ready  input  1  consumer takes data this cycle.
REQ-012 sel  output  1  source of out_data (0 = A, 1 = B); the mux select.

Function
REQ-013 Transfer on any port SHALL occur when its valid and ready are both 1 at a rising edge.
REQ-014 States SHALL be IDLE (output register empty), BUSY_A, BUSY_B (holding A or B data).
REQ-015 can_accept SHALL equal (state == IDLE) or out_ready.
REQ-016 At most one of a_ready/b_ready SHALL be 1 per cycle, and only when can_accept and the chosen requester's valid is 1.
REQ-017 Choice: only one valid -> that one; both valid -> requester named by priority pointer.
REQ-018 ready SHALL be combinational from valid, out_ready and state; valid SHALL NOT depend on ready.
REQ-019 On accept, priority pointer SHALL point to the other requester next cycle; otherwise unchanged.
REQ-020 Latency: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N.
REQ-021 Transitions: IDLE->BUSY_x on accept from x; BUSY_x->IDLE on out_ready with no accept; BUSY_x->BUSY_y on out_ready plus accept from y (same cycle drain and fill, throughput 1/cycle); BUSY_x holds when out_ready=0.
REQ-022 While out_valid=1 and out_ready=0, out_data and sel SHALL remain stable.
REQ-023 sel SHALL reflect source of held data; in IDLE sel SHALL retain last value.
REQ-024 Both requesters continuously valid SHALL be served strictly alternately.

Reset
REQ-025 On rst_n low, immediately: state IDLE, out_valid 0, out_data 0, sel 0, pointer = PRIO_RESET, a_ready/b_ready 0.
REQ-026 Reset mid-transfer SHALL discard held data; no output beat after release until a new accept.
REQ-027 Reset release SHALL be used synchronously; first accept is possible at the first edge after release.

Configuration
REQ-028 Macro MUX_ARB_STATS_EN SHALL add outputs gnt_cnt_a and gnt_cnt_b (8 bits each, saturating at 255, counting accepts, reset to 0).
REQ-029 Without MUX_ARB_STATS_EN those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 Shared package mux_arb_pkg SHALL hold the state enum (IDLE, BUSY_A, BUSY_B), source constants SRC_A=0/SRC_B=1 and the counter width 8.
REQ-031 One sub-module rr_pick2 (two requests, pointer -> one-hot grant) SHALL be used; the existing 2:1 mux is instantiated for data selection with sel driven by the grant.

Verification
REQ-032 Reset: assert rst_n=0 mid-BUSY_A -> out_valid=0, pointer=PRIO_RESET, no stale beat after release.
REQ-033 Single requester: a_valid=1, a_data=1, out_ready=1 -> a_ready=1 each cycle, out_data=1, sel=0, one cycle later.
REQ-034 Contention: a_valid=b_valid=1 for 6 cycles, a_data=0, b_data=1, out_ready=1 -> sel sequence 0,1,0,1,0,1 with PRIO_RESET=0.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles with B data 1 held -> a_ready=b_ready=0, out_data=1, sel=1 stable; release -> drain plus next accept same cycle.
REQ-036 Idle gap: single beat from B, then no valids -> state returns IDLE, out_valid=0, sel stays 1.
REQ-037 With MUX_ARB_STATS_EN: 300 accepts from A -> gnt_cnt_a=255, gnt_cnt_b unchanged.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-input round-robin mux arbiter.
//   state_e : output-register occupancy (IDLE, BUSY_A, BUSY_B)
//   SRC_A / SRC_B : source encoding used for sel and the priority pointer
//   CNT_W : width of the optional grant counters (MUX_ARB_STATS_EN)
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_A = 2'd1,
      BUSY_B = 2'd2
   } state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 data multiplexer.
//   in0_i / in1_i : data inputs, sel_i : 0 picks in0_i, 1 picks in1_i
//   out_o         : selected data
module mux2 #(
   parameter int unsigned W = 1
) (
   input  logic [W-1:0] in0_i,
   input  logic [W-1:0] in1_i,
   input  logic         sel_i,
   output logic [W-1:0] out_o
);

   assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: converts two requests and a priority
// pointer into a one-hot (or zero) grant.
//   req_a_i / req_b_i : requests
//   ptr_i             : favoured requester on contention (SRC_A / SRC_B)
//   gnt_o             : {grant_b, grant_a}, at most one bit set
module rr_pick2
   import mux_arb_pkg::*;
(
   input  logic       req_a_i,
   input  logic       req_b_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o    = 2'b00;
      gnt_o[0] = req_a_i & (~req_b_i | (ptr_i == SRC_A));
      gnt_o[1] = req_b_i & (~req_a_i | (ptr_i == SRC_B));
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output stage.
// Two valid/ready requesters (A, B) compete for one output register; the
// winner's data is captured through a 2:1 mux and presented on out_data.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   a_valid/a_data/a_ready      : requester A
//   b_valid/b_data/b_ready      : requester B
//   out_valid/out_data/out_ready: registered output
//   sel                         : source of held data (0 = A, 1 = B)
// Optional feature: define MUX_ARB_STATS_EN to add saturating 8-bit grant
// counters gnt_cnt_a / gnt_cnt_b.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned DATA_W     = 1,
   parameter logic        PRIO_RESET = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
`ifdef MUX_ARB_STATS_EN
   output logic [CNT_W-1:0]  gnt_cnt_a,
   output logic [CNT_W-1:0]  gnt_cnt_b,
`endif
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              sel
);

   state_e            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic              can_accept;
   logic [1:0]        gnt;
   logic [DATA_W-1:0] mux_data;
   logic              accept;

   rr_pick2 u_pick (
      .req_a_i (a_valid),
      .req_b_i (b_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt)
   );

   // Grant bit for B doubles as the mux select; zero grant defaults to A,
   // which is harmless because nothing is captured without an accept.
   mux2 #(
      .W (DATA_W)
   ) u_mux (
      .in0_i (a_data),
      .in1_i (b_data),
      .sel_i (gnt[1]),
      .out_o (mux_data)
   );

   assign can_accept = (state_q == IDLE) | out_ready;

   // Readies are masked while reset is asserted so nothing is acknowledged
   // that the reset would then throw away.
   assign a_ready = rst_n & can_accept & gnt[0];
   assign b_ready = rst_n & can_accept & gnt[1];
   assign accept  = a_ready | b_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      if (accept) begin
         // Fill (possibly in the same cycle as a drain).
         state_d = gnt[1] ? BUSY_B : BUSY_A;
         sel_d   = gnt[1] ? SRC_B : SRC_A;
         ptr_d   = gnt[1] ? SRC_A : SRC_B;
         data_d  = mux_data;
      end else if (state_q != IDLE && out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= PRIO_RESET;
         sel_q   <= SRC_A;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = (state_q != IDLE);
   assign out_data  = data_q;
   assign sel       = sel_q;

`ifdef MUX_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (a_ready && cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (b_ready && cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign gnt_cnt_a = cnt_a_q;
   assign gnt_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (DATA_W=1, PRIO_RESET=0).
// Inputs change 1 time unit after a rising edge; combinational readies are
// sampled 1 unit after that, registered outputs 1 unit after the next edge.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       a_valid, b_valid;
   logic [0:0] a_data, b_data;
   logic       a_ready, b_ready;
   logic       out_valid;
   logic [0:0] out_data;
   logic       out_ready;
   logic       sel;
`ifdef MUX_ARB_STATS_EN
   logic [7:0] gnt_cnt_a, gnt_cnt_b;
`endif

   int n_vec = 0;
   int n_err = 0;

   mux_rr_arbiter #(
      .DATA_W     (1),
      .PRIO_RESET (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
`ifdef MUX_ARB_STATS_EN
      .gnt_cnt_a (gnt_cnt_a),
      .gnt_cnt_b (gnt_cnt_b),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      a_data    = 1'b0;
      b_data    = 1'b0;
      out_ready = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      // Reset values, with requests pending during reset.
      rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      a_data = 1'b1; b_data = 1'b1;
      #3;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 1'b0 || sel !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got valid=%b data=%b sel=%b, want 0 0 0",
                  out_valid, out_data, sel);
      end
      n_vec++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready: got a_ready=%b b_ready=%b, want 0 0", a_ready, b_ready);
      end
      apply_reset();
      // Fill with A and hold it (BUSY_A), pointer now favours B.
      a_valid = 1'b1; a_data = 1'b1; out_ready = 1'b0;
      tick();
      a_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 1'b1 || sel !== 1'b0) begin
         n_err++;
         $display("FAIL busy_a_before_reset: got valid=%b data=%b sel=%b, want 1 1 0",
                  out_valid, out_data, sel);
      end
      // Asynchronous reset mid-transfer.
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 1'b0 || sel !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_busy: got valid=%b data=%b sel=%b, want 0 0 0",
                  out_valid, out_data, sel);
      end
      #10;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_stale_beat[%0d]: got out_valid=%b, want 0", i, out_valid);
         end
      end
      // Pointer must be back at A after reset.
      a_valid = 1'b1; b_valid = 1'b1; a_data = 1'b0; b_data = 1'b1;
      #1;
      n_vec++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ptr_after_reset: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
      end
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      a_valid = 1'b1; a_data = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready[%0d]: got a_ready=%b b_ready=%b, want 1 0",
                     i, a_ready, b_ready);
         end
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== 1'b1 || sel !== 1'b0) begin
            n_err++;
            $display("FAIL single_out[%0d]: got valid=%b data=%b sel=%b, want 1 1 0",
                     i, out_valid, out_data, sel);
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic test_contention();
      logic [5:0] exp_sel;
      exp_sel = 6'b101010; // bit i = expected sel of beat i: 0,1,0,1,0,1
      apply_reset();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 1'b0; b_data = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_vec++;
         if (a_ready !== ~exp_sel[i] || b_ready !== exp_sel[i]) begin
            n_err++;
            $display("FAIL contention_ready[%0d]: got a_ready=%b b_ready=%b, want %b %b",
                     i, a_ready, b_ready, ~exp_sel[i], exp_sel[i]);
         end
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || sel !== exp_sel[i] || out_data !== exp_sel[i]) begin
            n_err++;
            $display("FAIL contention_out[%0d]: got valid=%b sel=%b data=%b, want 1 %b %b",
                     i, out_valid, sel, out_data, exp_sel[i], exp_sel[i]);
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      b_valid = 1'b1; b_data = 1'b1; out_ready = 1'b1;
      tick();
      // Held B beat, both requesters pending, consumer stalled.
      a_valid = 1'b1; a_data = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready[%0d]: got a_ready=%b b_ready=%b, want 0 0",
                     i, a_ready, b_ready);
         end
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== 1'b1 || sel !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got valid=%b data=%b sel=%b, want 1 1 1",
                     i, out_valid, out_data, sel);
         end
      end
      // Release: drain B and accept A (pointer favours A) in the same cycle.
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL release_ready: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 1'b0 || sel !== 1'b0) begin
         n_err++;
         $display("FAIL release_fill: got valid=%b data=%b sel=%b, want 1 0 0",
                  out_valid, out_data, sel);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_idle_gap();
      apply_reset();
      b_valid = 1'b1; b_data = 1'b1; out_ready = 1'b1;
      #1;
      n_vec++;
      if (b_ready !== 1'b1) begin
         n_err++;
         $display("FAIL gap_b_ready: got %b, want 1", b_ready);
      end
      tick();
      b_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || sel !== 1'b1) begin
         n_err++;
         $display("FAIL gap_beat: got valid=%b sel=%b, want 1 1", out_valid, sel);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0 || sel !== 1'b1) begin
            n_err++;
            $display("FAIL gap_idle[%0d]: got valid=%b sel=%b, want 0 1", i, out_valid, sel);
         end
      end
   endtask

`ifdef MUX_ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      n_vec++;
      if (gnt_cnt_a !== 8'd0 || gnt_cnt_b !== 8'd0) begin
         n_err++;
         $display("FAIL stats_reset: got a=%0d b=%0d, want 0 0", gnt_cnt_a, gnt_cnt_b);
      end
      a_valid = 1'b1; a_data = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      a_valid = 1'b0;
      n_vec++;
      if (gnt_cnt_a !== 8'd255 || gnt_cnt_b !== 8'd0) begin
         n_err++;
         $display("FAIL stats_saturate: got a=%0d b=%0d, want 255 0", gnt_cnt_a, gnt_cnt_b);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_idle_gap();
`ifdef MUX_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
